// File: rtl/cond_flop_em_pkg.sv
// Shared definitions for the execute-stage conditional-execution unit:
// ARM condition-code encodings, NZCV flag bit positions and FlagWrite bit roles.
package cond_flop_em_pkg;

  // Width of the architectural flag register {N,Z,C,V}
  localparam int NZCV_W = 4;

  // Flag bit positions inside the {N,Z,C,V} vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagWrite bit roles: bit1 updates N,Z; bit0 updates C,V
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

  // ARM condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_flop_em_if.sv
// Execute/memory boundary bundle: stage control, ungated E-stage inputs,
// registered M-stage outputs, branch redirect and the current flags.
interface cond_flop_em_if
  import cond_flop_em_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              en;
  logic              flush;
  logic              PCSrcE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic              BranchE;
  logic [1:0]        FlagWriteE;
  logic [3:0]        CondE;
  logic [NZCV_W-1:0] ALUFlagsE;
  logic [DATA_W-1:0] ALUResultE;
  logic [DATA_W-1:0] WriteDataE;
  logic [REG_AW-1:0] WA3E;
  logic              PCSrcM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [REG_AW-1:0] WA3M;
  logic              BranchTakenE;
  logic [NZCV_W-1:0] FlagsE;

  // Upstream side: drives the execute stage and observes the memory stage
  modport master (
    output en, flush, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE,
           FlagWriteE, CondE, ALUFlagsE, ALUResultE, WriteDataE, WA3E,
    input  PCSrcM, RegWriteM, MemtoRegM, MemWriteM, ALUResultM, WriteDataM,
           WA3M, BranchTakenE, FlagsE
  );

  // The conditional-execution / pipeline-register block itself
  modport slave (
    input  en, flush, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE,
           FlagWriteE, CondE, ALUFlagsE, ALUResultE, WriteDataE, WA3E,
    output PCSrcM, RegWriteM, MemtoRegM, MemWriteM, ALUResultM, WriteDataM,
           WA3M, BranchTakenE, FlagsE
  );
endinterface

// File: rtl/cond_flop_em_cond_check.sv
// Pure combinational ARM condition evaluator: (CondE, FlagsE) -> CondExE.
// Kept stand-alone so property checks can reuse the same decode.
module cond_check
  import cond_flop_em_pkg::*;
(
  input  logic [3:0]        CondE,
  input  logic [NZCV_W-1:0] FlagsE,
  output logic              CondExE
);
  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = FlagsE[FLAG_N];
  assign z_s = FlagsE[FLAG_Z];
  assign c_s = FlagsE[FLAG_C];
  assign v_s = FlagsE[FLAG_V];

  // Decode the condition field against the current flags; 1111 never executes
  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      COND_EQ: CondExE = z_s;
      COND_NE: CondExE = ~z_s;
      COND_CS: CondExE = c_s;
      COND_CC: CondExE = ~c_s;
      COND_MI: CondExE = n_s;
      COND_PL: CondExE = ~n_s;
      COND_VS: CondExE = v_s;
      COND_VC: CondExE = ~v_s;
      COND_HI: CondExE = c_s & ~z_s;
      COND_LS: CondExE = ~c_s | z_s;
      COND_GE: CondExE = (n_s == v_s);
      COND_LT: CondExE = (n_s != v_s);
      COND_GT: CondExE = ~z_s & (n_s == v_s);
      COND_LE: CondExE = z_s | (n_s != v_s);
      COND_AL: CondExE = 1'b1;
      COND_NV: CondExE = 1'b0;
      default: CondExE = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_flop_em.sv
// Execute-stage conditional execution fused with the E->M pipeline register.
// Holds NZCV, gates PCSrc/RegWrite/MemWrite by the evaluated condition,
// registers controls and data into M, and drives the branch redirect.
module cond_flop_em
  import cond_flop_em_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
)
(
  input  logic          clk,
  input  logic          reset,
  cond_flop_em_if.slave bus
);
  logic              cond_ex_s;
  logic              flag_load_s;
  logic              pcsrc_g_s;
  logic              reg_write_g_s;
  logic              mem_write_g_s;
  logic [NZCV_W-1:0] flags_r;
  logic              pcsrc_r;
  logic              reg_write_r;
  logic              memto_reg_r;
  logic              mem_write_r;
  logic [DATA_W-1:0] alu_result_r;
  logic [DATA_W-1:0] write_data_r;
  logic [REG_AW-1:0] wa3_r;

  cond_check u_cond_check (
    .CondE   (bus.CondE),
    .FlagsE  (flags_r),
    .CondExE (cond_ex_s)
  );

  // Flags only move when the instruction actually executes and the stage advances
  assign flag_load_s = bus.en & ~bus.flush & cond_ex_s;

  // Suppress architectural side effects of instructions whose condition fails
  always_comb begin
    pcsrc_g_s     = bus.PCSrcE    & cond_ex_s;
    reg_write_g_s = bus.RegWriteE & cond_ex_s;
    mem_write_g_s = bus.MemWriteE & cond_ex_s;
  end

  // NZCV register: N,Z and C,V pairs update independently; flush and stall hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else begin
      if (flag_load_s & bus.FlagWriteE[FW_NZ]) begin
        flags_r[FLAG_N] <= bus.ALUFlagsE[FLAG_N];
        flags_r[FLAG_Z] <= bus.ALUFlagsE[FLAG_Z];
      end
      if (flag_load_s & bus.FlagWriteE[FW_CV]) begin
        flags_r[FLAG_C] <= bus.ALUFlagsE[FLAG_C];
        flags_r[FLAG_V] <= bus.ALUFlagsE[FLAG_V];
      end
    end
  end

  // E->M register: flush inserts a bubble even while stalled, en=0 holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcsrc_r      <= 1'b0;
      reg_write_r  <= 1'b0;
      memto_reg_r  <= 1'b0;
      mem_write_r  <= 1'b0;
      alu_result_r <= {DATA_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      wa3_r        <= {REG_AW{1'b0}};
    end else if (bus.flush) begin
      pcsrc_r      <= 1'b0;
      reg_write_r  <= 1'b0;
      memto_reg_r  <= 1'b0;
      mem_write_r  <= 1'b0;
      alu_result_r <= {DATA_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      wa3_r        <= {REG_AW{1'b0}};
    end else if (bus.en) begin
      pcsrc_r      <= pcsrc_g_s;
      reg_write_r  <= reg_write_g_s;
      memto_reg_r  <= bus.MemtoRegE;
      mem_write_r  <= mem_write_g_s;
      alu_result_r <= bus.ALUResultE;
      write_data_r <= bus.WriteDataE;
      wa3_r        <= bus.WA3E;
    end else begin
      pcsrc_r      <= pcsrc_r;
      reg_write_r  <= reg_write_r;
      memto_reg_r  <= memto_reg_r;
      mem_write_r  <= mem_write_r;
      alu_result_r <= alu_result_r;
      write_data_r <= write_data_r;
      wa3_r        <= wa3_r;
    end
  end

  // Redirect is deliberately independent of en/flush to keep the hazard path acyclic
  assign bus.BranchTakenE = bus.BranchE & cond_ex_s;
  assign bus.FlagsE       = flags_r;
  assign bus.PCSrcM       = pcsrc_r;
  assign bus.RegWriteM    = reg_write_r;
  assign bus.MemtoRegM    = memto_reg_r;
  assign bus.MemWriteM    = mem_write_r;
  assign bus.ALUResultM   = alu_result_r;
  assign bus.WriteDataM   = write_data_r;
  assign bus.WA3M         = wa3_r;
endmodule

// File: tb/tb_cond_flop_em.sv
// Self-checking bench for cond_flop_em: directed scenarios plus randomized
// traffic compared against a behavioural model of the E/M stage.
module tb_cond_flop_em;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  logic clk = 1'b0;
  logic reset;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  cond_flop_em_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  cond_flop_em #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state
  logic [3:0]        m_flags;
  logic              e_pcsrc, e_rw, e_mtr, e_mw;
  logic [DATA_W-1:0] e_alu, e_wd;
  logic [REG_AW-1:0] e_wa3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ARM semantics: cond[3:1] picks a base test, cond[0] inverts it; 111x is always/never
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (cond[0] == 1'b0);
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    e_pcsrc = 1'b0; e_rw = 1'b0; e_mtr = 1'b0; e_mw = 1'b0;
    e_alu = '0; e_wd = '0; e_wa3 = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_ctl"}, {60'd0, bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM},
          {60'd0, e_pcsrc, e_rw, e_mtr, e_mw});
    check({tag, "_alu"}, 64'(bus.ALUResultM), 64'(e_alu));
    check({tag, "_wd"}, 64'(bus.WriteDataM), 64'(e_wd));
    check({tag, "_wa3"}, 64'(bus.WA3M), 64'(e_wa3));
    check({tag, "_flags"}, 64'(bus.FlagsE), 64'(m_flags));
  endtask

  // Advance one clock: update the model from the current inputs, then compare
  task automatic tick(input string tag);
    logic ce;
    ce = cond_holds(bus.CondE, m_flags);
    if (bus.flush) begin
      e_pcsrc = 1'b0; e_rw = 1'b0; e_mtr = 1'b0; e_mw = 1'b0;
      e_alu = '0; e_wd = '0; e_wa3 = '0;
    end else if (bus.en) begin
      e_pcsrc = bus.PCSrcE & ce;
      e_rw    = bus.RegWriteE & ce;
      e_mtr   = bus.MemtoRegE;
      e_mw    = bus.MemWriteE & ce;
      e_alu   = bus.ALUResultE;
      e_wd    = bus.WriteDataE;
      e_wa3   = bus.WA3E;
      if (ce && bus.FlagWriteE[1]) m_flags[3:2] = bus.ALUFlagsE[3:2];
      if (ce && bus.FlagWriteE[0]) m_flags[1:0] = bus.ALUFlagsE[1:0];
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    bus.en = 1'b1; bus.flush = 1'b0;
    bus.PCSrcE = 1'b0; bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0;
    bus.MemWriteE = 1'b0; bus.BranchE = 1'b0;
    bus.FlagWriteE = 2'b00; bus.CondE = 4'b1110; bus.ALUFlagsE = 4'b0000;
    bus.ALUResultE = '0; bus.WriteDataE = '0; bus.WA3E = '0;
  endtask

  task automatic randomize_inputs();
    bus.en         = ($urandom_range(0, 3) != 0);
    bus.flush      = ($urandom_range(0, 7) == 0);
    bus.PCSrcE     = 1'($urandom);
    bus.RegWriteE  = 1'($urandom);
    bus.MemtoRegE  = 1'($urandom);
    bus.MemWriteE  = 1'($urandom);
    bus.BranchE    = 1'($urandom);
    bus.FlagWriteE = 2'($urandom);
    bus.CondE      = 4'($urandom);
    bus.ALUFlagsE  = 4'($urandom);
    bus.ALUResultE = $urandom;
    bus.WriteDataE = $urandom;
    bus.WA3E       = 4'($urandom);
  endtask

  // Set the flag register to f via an always-executing flag-setting op
  task automatic set_flags(input logic [3:0] f, input string tag);
    idle();
    bus.ALUFlagsE = f; bus.FlagWriteE = 2'b11; bus.CondE = 4'b1110;
    tick(tag);
  endtask

  // Main stimulus sequence
  initial begin
    // Reset with every input driven high
    reset = 1'b1;
    bus.en = 1'b1; bus.flush = 1'b1;
    bus.PCSrcE = 1'b1; bus.RegWriteE = 1'b1; bus.MemtoRegE = 1'b1;
    bus.MemWriteE = 1'b1; bus.BranchE = 1'b1;
    bus.FlagWriteE = 2'b11; bus.CondE = 4'b1111; bus.ALUFlagsE = 4'b1111;
    bus.ALUResultE = '1; bus.WriteDataE = '1; bus.WA3E = '1;
    model_reset();
    #1;
    check_all("reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all("reset_hold");
    end
    #2 reset = 1'b0;
    idle();
    tick("idle");

    // Compare then branch-if-equal, flags set
    set_flags(4'b0100, "cmp_eq");
    check("cmp_flags", 64'(bus.FlagsE), 64'h4);
    idle(); bus.BranchE = 1'b1; bus.CondE = 4'b0000;
    #1 check("beq_taken", 64'(bus.BranchTakenE), 64'h1);
    tick("beq");

    // Compare then branch-if-equal, flags clear
    set_flags(4'b0000, "cmp_ne");
    idle(); bus.BranchE = 1'b1; bus.CondE = 4'b0000;
    #1 check("beq_not_taken", 64'(bus.BranchTakenE), 64'h0);
    tick("beq2");

    // Failed condition suppresses writes and flag update, data still flows
    idle();
    bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.CondE = 4'b0000;
    bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 4'b1111; bus.ALUResultE = 32'hDEADBEEF;
    tick("suppress");
    check("suppress_rw", 64'(bus.RegWriteM), 64'h0);
    check("suppress_alu", 64'(bus.ALUResultM), 64'hDEADBEEF);
    check("suppress_flags", 64'(bus.FlagsE), 64'h0);

    // Partial flag write: only N,Z
    set_flags(4'b1111, "flags_all");
    idle(); bus.FlagWriteE = 2'b10; bus.ALUFlagsE = 4'b0000;
    tick("partial");
    check("partial_flags", 64'(bus.FlagsE), 64'h3);

    // Stall two cycles with changing inputs
    idle(); bus.RegWriteE = 1'b1; bus.ALUResultE = 32'h12345678; bus.WA3E = 4'd9;
    tick("pre_stall");
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      bus.en = 1'b0; bus.flush = 1'b0;
      tick("stall");
    end
    check("stall_alu", 64'(bus.ALUResultM), 64'h12345678);

    // Flush while stalled still inserts a bubble and leaves flags alone
    idle(); bus.en = 1'b0; bus.flush = 1'b1;
    bus.RegWriteE = 1'b1; bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 4'b1010;
    tick("flush_stall");
    check("flush_rw", 64'(bus.RegWriteM), 64'h0);
    check("flush_flags", 64'(bus.FlagsE), 64'h3);

    // Full sweep of 16 conditions against 16 flag values (stage stalled while probing)
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f), "sweep_set");
      idle(); bus.en = 1'b0; bus.BranchE = 1'b1;
      for (int c = 0; c < 16; c++) begin
        bus.CondE = 4'(c);
        #1 check($sformatf("cond_%0h_f%0h", c, f), 64'(bus.BranchTakenE),
                 64'(cond_holds(4'(c), 4'(f))));
      end
      @(posedge clk); #1;
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      #1 check("rand_branch", 64'(bus.BranchTakenE), 64'(bus.BranchE & cond_holds(bus.CondE, m_flags)));
      tick("rand");
    end

    // Asynchronous reset mid-cycle clears without a clock edge
    set_flags(4'b1101, "pre_areset");
    idle(); bus.RegWriteE = 1'b1; bus.ALUResultE = 32'hCAFEF00D; bus.WA3E = 4'd5;
    tick("pre_areset_load");
    #1 reset = 1'b1;
    model_reset();
    #1 check_all("areset");
    @(posedge clk); #1 reset = 1'b0;
    idle(); bus.MemtoRegE = 1'b1; bus.ALUResultE = 32'h0BADCAFE;
    tick("post_reset_load");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
